axi_mem_responder: RTL and testbench

AXI4 slave memory model that answers the PCIe core's outbound AXI master port (m_axi_*), serving the inbound TLP memory reads and writes that the core issues. It holds a word-addressed RAM and runs independent write (AW/W/B) and read (AR/R) state machines. It supports INCR bursts, byte strobes and out-of-range error responses. It is used as the host-memory endpoint in PCIe simulation benches and in FPGA loopback builds.

---
 rtl/axi_mem_responder_if.sv | 69 ++++++
 rtl/axi_mem_responder.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_responder_if.sv
// AXI4 slave-side bundle for axi_mem_responder: AW/W/B write channels and
// AR/R read channels. Burst type is implicitly INCR, so no awburst/arburst.
// The slave modport is used by the memory model, master by whatever drives it.
interface axi_mem_if #(
    parameter int ID_WIDTH   = 6,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 256
);
    // Write address channel
    logic                    awvalid;
    logic                    awready;
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;

    // Write data channel
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;

    // Write response channel
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;

    // Read address channel
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;

    // Read data channel
    logic                    rvalid;
    logic                    rready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;

    modport slave (
        input  awvalid, awid, awaddr, awlen,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, arid, araddr, arlen,
        output arready,
        output rvalid, rid, rdata, rresp, rlast,
        input  rready
    );

    modport master (
        output awvalid, awid, awaddr, awlen,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, arid, araddr, arlen,
        input  arready,
        input  rvalid, rid, rdata, rresp, rlast,
        output rready
    );
endinterface

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 slave memory model serving INCR bursts from the
// PCIe core's outbound master port. Word-addressed RAM built from one byte
// lane per strobe bit, with independent write (AW/W/B) and read (AR/R) FSMs.
//
// Build option AXI_MEM_RESP_ERR_EN:
//   defined   - beats beyond 2^MEM_DEPTH_LG2 words get SLVERR (writes dropped,
//               reads return zero) and a wlast on the wrong beat gives SLVERR.
//   undefined - the word index wraps modulo the RAM depth, every response is
//               OKAY and wlast simply ends the burst.
module axi_mem_responder #(
    parameter int ID_WIDTH      = 6,
    parameter int ADDR_WIDTH    = 64,
    parameter int DATA_WIDTH    = 256,
    parameter int MEM_DEPTH_LG2 = 10
) (
    input  logic      clk,
    input  logic      rst,
    axi_mem_if.slave  s_axi
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int BYTE_LG2   = $clog2(STRB_WIDTH);
    localparam int MEM_DEPTH  = 1 << MEM_DEPTH_LG2;
`ifdef AXI_MEM_RESP_ERR_EN
    localparam int RANGE_LG2  = BYTE_LG2 + MEM_DEPTH_LG2;
`endif
    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(STRB_WIDTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    // ------------------------------------------------------------------
    // Common
    // ------------------------------------------------------------------
    // Goes high the first edge rst is seen low; keeps both address readys
    // low through reset and for one cycle after it.
    logic live_reg;

    // Track whether reset has been released so the address channels can open.
    always_ff @(posedge clk) begin
        if (rst) begin
            live_reg <= 1'b0;
        end else begin
            live_reg <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    w_state_t                  w_state_reg, w_state_next;
    logic [ID_WIDTH-1:0]       w_id_reg;
    logic [ADDR_WIDTH-1:0]     w_addr_reg;
    logic                      w_err_reg;
`ifdef AXI_MEM_RESP_ERR_EN
    logic [7:0]                w_len_reg;
    logic [7:0]                w_beat_reg;
`endif
    logic                      aw_ready, w_ready, b_valid;
    logic [1:0]                b_resp;
    logic                      aw_fire, w_fire, b_fire;
    logic                      w_in_range, w_beat_err;
    logic                      ram_we;
    logic [MEM_DEPTH_LG2-1:0]  w_idx;

    assign aw_fire = s_axi.awvalid && aw_ready;
    assign w_fire  = s_axi.wvalid  && w_ready;
    assign b_fire  = b_valid       && s_axi.bready;
    assign w_idx   = w_addr_reg[BYTE_LG2 +: MEM_DEPTH_LG2];
    assign ram_we  = w_fire && w_in_range;

    // Per-beat range and wlast-placement checks for the current W beat.
    always_comb begin
        w_in_range = 1'b1;
        w_beat_err = 1'b0;
`ifdef AXI_MEM_RESP_ERR_EN
        w_in_range = (w_addr_reg >> RANGE_LG2) == '0;
        w_beat_err = !w_in_range || (s_axi.wlast != (w_beat_reg == w_len_reg));
`else
        w_in_range = 1'b1;
        w_beat_err = 1'b0;
`endif
    end

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_reg <= W_IDLE;
        end else begin
            w_state_reg <= w_state_next;
        end
    end

    // Write FSM next-state: the burst always ends on the wlast handshake.
    always_comb begin
        w_state_next = w_state_reg;
        case (w_state_reg)
            W_IDLE:  if (aw_fire) w_state_next = W_DATA;
            W_DATA:  if (w_fire && s_axi.wlast) w_state_next = W_RESP;
            W_RESP:  if (b_fire) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    // Write FSM outputs decoded from state and registered burst status.
    always_comb begin
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
        b_resp   = RESP_OKAY;
        case (w_state_reg)
            W_IDLE:  aw_ready = live_reg;
            W_DATA:  w_ready  = 1'b1;
            W_RESP: begin
                b_valid = 1'b1;
                b_resp  = w_err_reg ? RESP_SLVERR : RESP_OKAY;
            end
            default: ;
        endcase
    end

    // Write burst bookkeeping: capture AW, advance one word per W beat,
    // accumulate the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_id_reg   <= '0;
            w_addr_reg <= '0;
            w_err_reg  <= 1'b0;
        end else if (aw_fire) begin
            w_id_reg   <= s_axi.awid;
            w_addr_reg <= s_axi.awaddr;
            w_err_reg  <= 1'b0;
        end else if (w_fire) begin
            w_addr_reg <= w_addr_reg + BEAT_BYTES;
            if (w_beat_err) begin
                w_err_reg <= 1'b1;
            end
        end
    end

`ifdef AXI_MEM_RESP_ERR_EN
    // Beat counter used only to check where wlast lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_len_reg  <= '0;
            w_beat_reg <= '0;
        end else if (aw_fire) begin
            w_len_reg  <= s_axi.awlen;
            w_beat_reg <= '0;
        end else if (w_fire) begin
            w_beat_reg <= w_beat_reg + 8'd1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    r_state_t                  r_state_reg, r_state_next;
    logic [ID_WIDTH-1:0]       r_id_reg;
    logic [ADDR_WIDTH-1:0]     r_addr_reg;
    logic [7:0]                r_len_reg;
    logic [7:0]                r_beat_reg;
    logic [1:0]                r_resp_reg;
    logic                      ar_ready, r_valid, r_last;
    logic                      ar_fire, r_fire, r_fetch;
    logic                      r_in_range;
    logic [MEM_DEPTH_LG2-1:0]  r_idx;
    logic [DATA_WIDTH-1:0]     rdata_bus;

    assign ar_fire = s_axi.arvalid && ar_ready;
    assign r_fire  = r_valid       && s_axi.rready;
    assign r_fetch = (r_state_reg == R_FETCH);
    assign r_idx   = r_addr_reg[BYTE_LG2 +: MEM_DEPTH_LG2];

    // Range check for the beat currently being fetched.
    always_comb begin
        r_in_range = 1'b1;
`ifdef AXI_MEM_RESP_ERR_EN
        r_in_range = (r_addr_reg >> RANGE_LG2) == '0;
`else
        r_in_range = 1'b1;
`endif
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_reg <= R_IDLE;
        end else begin
            r_state_reg <= r_state_next;
        end
    end

    // Read FSM next-state: one fetch cycle precedes every data beat.
    always_comb begin
        r_state_next = r_state_reg;
        case (r_state_reg)
            R_IDLE:  if (ar_fire) r_state_next = R_FETCH;
            R_FETCH: r_state_next = R_DATA;
            R_DATA:  if (r_fire) r_state_next = r_last ? R_IDLE : R_FETCH;
            default: r_state_next = R_IDLE;
        endcase
    end

    // Read FSM outputs decoded from state and the beat counter.
    always_comb begin
        ar_ready = 1'b0;
        r_valid  = 1'b0;
        r_last   = 1'b0;
        case (r_state_reg)
            R_IDLE:  ar_ready = live_reg;
            R_DATA: begin
                r_valid = 1'b1;
                r_last  = (r_beat_reg == r_len_reg);
            end
            default: ;
        endcase
    end

    // Read burst bookkeeping: capture AR, advance per R handshake, and
    // register the per-beat response alongside the fetched data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_reg   <= '0;
            r_addr_reg <= '0;
            r_len_reg  <= '0;
            r_beat_reg <= '0;
            r_resp_reg <= RESP_OKAY;
        end else begin
            if (ar_fire) begin
                r_id_reg   <= s_axi.arid;
                r_addr_reg <= s_axi.araddr;
                r_len_reg  <= s_axi.arlen;
                r_beat_reg <= '0;
            end else if (r_fire) begin
                r_addr_reg <= r_addr_reg + BEAT_BYTES;
                r_beat_reg <= r_beat_reg + 8'd1;
            end
            if (r_fetch) begin
                r_resp_reg <= r_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM: one byte-wide array per strobe lane. Write and read live in
    // separate blocks, so a same-cycle fetch of a word being written
    // returns the old contents. The read register doubles as rdata.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
            logic [7:0] lane_mem [MEM_DEPTH];
            logic [7:0] lane_q;

            // Strobed byte write for this lane.
            always_ff @(posedge clk) begin
                if (ram_we && s_axi.wstrb[gi]) begin
                    lane_mem[w_idx] <= s_axi.wdata[gi*8 +: 8];
                end
            end

            // Registered lane read; out-of-range beats return zero.
            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_q <= 8'h00;
                end else if (r_fetch) begin
                    lane_q <= r_in_range ? lane_mem[r_idx] : 8'h00;
                end
            end

            assign rdata_bus[gi*8 +: 8] = lane_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Port drive
    // ------------------------------------------------------------------
    assign s_axi.awready = aw_ready;
    assign s_axi.wready  = w_ready;
    assign s_axi.bvalid  = b_valid;
    assign s_axi.bid     = w_id_reg;
    assign s_axi.bresp   = b_resp;
    assign s_axi.arready = ar_ready;
    assign s_axi.rvalid  = r_valid;
    assign s_axi.rid     = r_id_reg;
    assign s_axi.rdata   = rdata_bus;
    assign s_axi.rresp   = r_resp_reg;
    assign s_axi.rlast   = r_last;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: one task per scenario, inline checks,
// inputs driven and outputs sampled 1 ns after the rising edge.
`timescale 1ns/1ps
module tb_axi_mem_responder;
    localparam int ID_WIDTH      = 6;
    localparam int ADDR_WIDTH    = 64;
    localparam int DATA_WIDTH    = 256;
    localparam int MEM_DEPTH_LG2 = 10;
    localparam int TMO           = 64;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
`ifdef AXI_MEM_RESP_ERR_EN
    localparam logic [1:0] ERR_RESP = SLVERR;
`else
    localparam logic [1:0] ERR_RESP = OKAY;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic [DATA_WIDTH-1:0] word0_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_mem_if #(.ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) axi ();

    axi_mem_responder #(
        .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH_LG2(MEM_DEPTH_LG2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_axi(axi)
    );

    function automatic logic [DATA_WIDTH-1:0] pat(input logic [31:0] seed);
        return {8{seed}};
    endfunction

    // ---------------- channel drivers (no checking beyond timeouts) -------
    task automatic aw_put(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len);
        int n = 0;
        axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awvalid = 1'b1;
        while (axi.awready !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) begin vectors++; miscompares++; $display("FAIL aw_timeout awready got %b want 1", axi.awready); end
        $display("AW id=%0h addr=%0h len=%0d", id, addr, len);
        @(posedge clk); #1;
        axi.awvalid = 1'b0;
    endtask

    task automatic w_put(input logic [DATA_WIDTH-1:0] data, input logic [31:0] strb, input logic last);
        int n = 0;
        axi.wdata = data; axi.wstrb = strb; axi.wlast = last; axi.wvalid = 1'b1;
        while (axi.wready !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) begin vectors++; miscompares++; $display("FAIL w_timeout wready got %b want 1", axi.wready); end
        $display("W strb=%h last=%b data=%h", strb, last, data);
        @(posedge clk); #1;
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
    endtask

    task automatic b_get(output logic [5:0] id, output logic [1:0] resp);
        int n = 0;
        axi.bready = 1'b1;
        while (axi.bvalid !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) begin vectors++; miscompares++; $display("FAIL b_timeout bvalid got %b want 1", axi.bvalid); end
        id = axi.bid; resp = axi.bresp;
        $display("B id=%0h resp=%0d", id, resp);
        @(posedge clk); #1;
        axi.bready = 1'b0;
    endtask

    task automatic ar_put(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len, output int hs);
        int n = 0;
        axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arvalid = 1'b1;
        while (axi.arready !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) begin vectors++; miscompares++; $display("FAIL ar_timeout arready got %b want 1", axi.arready); end
        $display("AR id=%0h addr=%0h len=%0d", id, addr, len);
        hs = cyc + 1;
        @(posedge clk); #1;
        axi.arvalid = 1'b0;
    endtask

    task automatic r_get(output logic [DATA_WIDTH-1:0] data, output logic [1:0] resp,
                         output logic last, output logic [5:0] id, output int hs);
        int n = 0;
        axi.rready = 1'b1;
        while (axi.rvalid !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) begin vectors++; miscompares++; $display("FAIL r_timeout rvalid got %b want 1", axi.rvalid); end
        data = axi.rdata; resp = axi.rresp; last = axi.rlast; id = axi.rid;
        hs = cyc + 1;
        $display("R id=%0h resp=%0d last=%b data=%h", id, resp, last, data);
        @(posedge clk); #1;
        axi.rready = 1'b0;
    endtask

    // ---------------- scenarios ------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (axi.awready !== 1'b0) begin miscompares++; $display("FAIL rst_awready got %b want 0", axi.awready); end
        vectors++; if (axi.arready !== 1'b0) begin miscompares++; $display("FAIL rst_arready got %b want 0", axi.arready); end
        vectors++; if (axi.wready !== 1'b0) begin miscompares++; $display("FAIL rst_wready got %b want 0", axi.wready); end
        vectors++; if ({axi.bvalid, axi.bid, axi.bresp} !== 9'd0) begin miscompares++; $display("FAIL rst_b got %b/%h/%b want 0/0/0", axi.bvalid, axi.bid, axi.bresp); end
        vectors++; if ({axi.rvalid, axi.rlast, axi.rid, axi.rresp} !== 10'd0) begin miscompares++; $display("FAIL rst_r got %b/%b/%h/%b want all 0", axi.rvalid, axi.rlast, axi.rid, axi.rresp); end
        vectors++; if (axi.rdata !== '0) begin miscompares++; $display("FAIL rst_rdata got %h want 0", axi.rdata); end
        rst = 1'b0;
        vectors++; if (axi.awready !== 1'b0) begin miscompares++; $display("FAIL rst_release_early got %b want 0", axi.awready); end
        @(posedge clk); #1;
        vectors++; if ({axi.awready, axi.arready} !== 2'b11) begin miscompares++; $display("FAIL rst_release aw/ar got %b want 11", {axi.awready, axi.arready}); end
    endtask

    task automatic test_single_write();
        logic [5:0] id; logic [1:0] resp; logic last; logic [DATA_WIDTH-1:0] d; int e0, e1;
        aw_put(6'h15, 64'h40, 8'd0);
        w_put(pat(32'hA5A5A5A5), 32'hFFFFFFFF, 1'b1);
        vectors++; if (axi.bvalid !== 1'b1) begin miscompares++; $display("FAIL single_bvalid_timing got %b want 1", axi.bvalid); end
        b_get(id, resp);
        vectors++; if ({id, resp} !== {6'h15, OKAY}) begin miscompares++; $display("FAIL single_b got id=%h resp=%b want id=15 resp=00", id, resp); end
        ar_put(6'h2A, 64'h40, 8'd0, e0);
        r_get(d, resp, last, id, e1);
        vectors++; if (d !== pat(32'hA5A5A5A5)) begin miscompares++; $display("FAIL single_rdata got %h want a5..a5", d); end
        vectors++; if ({id, resp, last} !== {6'h2A, OKAY, 1'b1}) begin miscompares++; $display("FAIL single_r got id=%h resp=%b last=%b want 2a/00/1", id, resp, last); end
        vectors++; if (e1 - e0 !== 2) begin miscompares++; $display("FAIL single_latency got %0d want 2", e1 - e0); end
    endtask

    task automatic test_burst_strobe();
        logic [5:0] id; logic [1:0] resp; logic last; logic [DATA_WIDTH-1:0] d, p2, q2;
        logic [DATA_WIDTH-1:0] expw [4];
        int prev, hs;
        aw_put(6'h01, 64'h0, 8'd3);
        for (int i = 0; i < 4; i++) w_put(pat(32'h11110000 + i), 32'hFFFFFFFF, i == 3);
        b_get(id, resp);
        vectors++; if ({id, resp} !== {6'h01, OKAY}) begin miscompares++; $display("FAIL burst_b1 got id=%h resp=%b want 01/00", id, resp); end
        aw_put(6'h02, 64'h0, 8'd3);
        for (int i = 0; i < 4; i++) w_put(pat(32'hC0DE0000 + i), (i == 2) ? 32'h0000000F : 32'hFFFFFFFF, i == 3);
        b_get(id, resp);
        vectors++; if ({id, resp} !== {6'h02, OKAY}) begin miscompares++; $display("FAIL burst_b2 got id=%h resp=%b want 02/00", id, resp); end
        p2 = pat(32'h11110002); q2 = pat(32'hC0DE0002);
        expw[0] = pat(32'hC0DE0000); expw[1] = pat(32'hC0DE0001);
        expw[2] = {p2[255:32], q2[31:0]}; expw[3] = pat(32'hC0DE0003);
        word0_exp = expw[0];
        ar_put(6'h03, 64'h0, 8'd3, prev);
        for (int i = 0; i < 4; i++) begin
            r_get(d, resp, last, id, hs);
            vectors++; if (d !== expw[i]) begin miscompares++; $display("FAIL burst_rdata[%0d] got %h want %h", i, d, expw[i]); end
            vectors++; if ({id, resp, last} !== {6'h03, OKAY, i == 3}) begin miscompares++; $display("FAIL burst_rctl[%0d] got id=%h resp=%b last=%b want 03/00/%b", i, id, resp, last, i == 3); end
            vectors++; if (hs - prev !== 2) begin miscompares++; $display("FAIL burst_spacing[%0d] got %0d want 2", i, hs - prev); end
            prev = hs;
        end
    endtask

    task automatic test_out_of_range();
        logic [5:0] id; logic [1:0] resp; logic last; logic [DATA_WIDTH-1:0] d, exp_oor, exp_w0; int e;
`ifdef AXI_MEM_RESP_ERR_EN
        exp_oor = '0;
        exp_w0  = word0_exp;
`else
        exp_oor = pat(32'hBADC0FFE);
        exp_w0  = pat(32'hBADC0FFE);
`endif
        aw_put(6'h05, 64'h8000, 8'd0);
        w_put(pat(32'hBADC0FFE), 32'hFFFFFFFF, 1'b1);
        b_get(id, resp);
        vectors++; if ({id, resp} !== {6'h05, ERR_RESP}) begin miscompares++; $display("FAIL oor_b got id=%h resp=%b want 05/%b", id, resp, ERR_RESP); end
        ar_put(6'h06, 64'h8000, 8'd0, e);
        r_get(d, resp, last, id, e);
        vectors++; if ({d, resp, last} !== {exp_oor, ERR_RESP, 1'b1}) begin miscompares++; $display("FAIL oor_r got resp=%b last=%b data=%h want resp=%b data=%h", resp, last, d, ERR_RESP, exp_oor); end
        ar_put(6'h07, 64'h0, 8'd0, e);
        r_get(d, resp, last, id, e);
        vectors++; if ({d, resp} !== {exp_w0, OKAY}) begin miscompares++; $display("FAIL oor_word0 got resp=%b data=%h want 00/%h", resp, d, exp_w0); end
        word0_exp = exp_w0;
    endtask

    task automatic test_early_wlast();
        logic [5:0] id; logic [1:0] resp; logic last; logic [DATA_WIDTH-1:0] d; int e;
        aw_put(6'h08, 64'h200, 8'd3);
        w_put(pat(32'hE0E0E0E0), 32'hFFFFFFFF, 1'b0);
        w_put(pat(32'hE1E1E1E1), 32'hFFFFFFFF, 1'b1);
        vectors++; if ({axi.bvalid, axi.awready, axi.wready} !== 3'b100) begin miscompares++; $display("FAIL early_state got bvalid/awready/wready=%b want 100", {axi.bvalid, axi.awready, axi.wready}); end
        b_get(id, resp);
        vectors++; if ({id, resp} !== {6'h08, ERR_RESP}) begin miscompares++; $display("FAIL early_b got id=%h resp=%b want 08/%b", id, resp, ERR_RESP); end
        vectors++; if (axi.awready !== 1'b1) begin miscompares++; $display("FAIL early_awready got %b want 1", axi.awready); end
        ar_put(6'h09, 64'h200, 8'd1, e);
        r_get(d, resp, last, id, e);
        vectors++; if ({d, last} !== {pat(32'hE0E0E0E0), 1'b0}) begin miscompares++; $display("FAIL early_rd0 got last=%b data=%h want 0/e0..e0", last, d); end
        r_get(d, resp, last, id, e);
        vectors++; if ({d, last} !== {pat(32'hE1E1E1E1), 1'b1}) begin miscompares++; $display("FAIL early_rd1 got last=%b data=%h want 1/e1..e1", last, d); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] id; logic [1:0] resp; logic last; logic [DATA_WIDTH-1:0] d; int e; int n;
        fork
            begin
                aw_put(6'h09, 64'h400, 8'd1);
                w_put(pat(32'hF0F0F0F0), 32'hFFFFFFFF, 1'b0);
                w_put(pat(32'hF1F1F1F1), 32'hFFFFFFFF, 1'b1);
            end
            begin
                int ea;
                ar_put(6'h0A, 64'h200, 8'd1, ea);
            end
        join
        n = 0;
        while (!(axi.bvalid === 1'b1 && axi.rvalid === 1'b1) && n < TMO) begin @(posedge clk); #1; n++; end
        vectors++; if (n >= TMO) begin miscompares++; $display("FAIL b2b_valids got bvalid=%b rvalid=%b want 1/1", axi.bvalid, axi.rvalid); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++; if ({axi.bvalid, axi.bid, axi.bresp} !== {1'b1, 6'h09, OKAY}) begin miscompares++; $display("FAIL b2b_bhold[%0d] got %b/%h/%b want 1/09/00", i, axi.bvalid, axi.bid, axi.bresp); end
            vectors++; if ({axi.rvalid, axi.rid, axi.rlast, axi.rdata} !== {1'b1, 6'h0A, 1'b0, pat(32'hE0E0E0E0)}) begin miscompares++; $display("FAIL b2b_rhold[%0d] got %b/%h/%b/%h want 1/0a/0/e0..e0", i, axi.rvalid, axi.rid, axi.rlast, axi.rdata); end
        end
        b_get(id, resp);
        vectors++; if ({id, resp} !== {6'h09, OKAY}) begin miscompares++; $display("FAIL b2b_b got id=%h resp=%b want 09/00", id, resp); end
        r_get(d, resp, last, id, e);
        vectors++; if ({d, last} !== {pat(32'hE0E0E0E0), 1'b0}) begin miscompares++; $display("FAIL b2b_r0 got last=%b data=%h want 0/e0..e0", last, d); end
        r_get(d, resp, last, id, e);
        vectors++; if ({d, last} !== {pat(32'hE1E1E1E1), 1'b1}) begin miscompares++; $display("FAIL b2b_r1 got last=%b data=%h want 1/e1..e1", last, d); end
        ar_put(6'h0B, 64'h400, 8'd1, e);
        r_get(d, resp, last, id, e);
        vectors++; if (d !== pat(32'hF0F0F0F0)) begin miscompares++; $display("FAIL b2b_wr0 got %h want f0..f0", d); end
        r_get(d, resp, last, id, e);
        vectors++; if (d !== pat(32'hF1F1F1F1)) begin miscompares++; $display("FAIL b2b_wr1 got %h want f1..f1", d); end
    endtask

    task automatic test_reset_mid_burst();
        logic [5:0] id; logic [1:0] resp; logic last; logic [DATA_WIDTH-1:0] d; int e; int n;
        ar_put(6'h0C, 64'h0, 8'd7, e);
        r_get(d, resp, last, id, e);
        vectors++; if ({d, last} !== {word0_exp, 1'b0}) begin miscompares++; $display("FAIL mid_r0 got last=%b data=%h want 0/%h", last, d, word0_exp); end
        r_get(d, resp, last, id, e);
        vectors++; if ({d, last} !== {pat(32'hC0DE0001), 1'b0}) begin miscompares++; $display("FAIL mid_r1 got last=%b data=%h want 0/c0de0001..", last, d); end
        n = 0;
        while (axi.rvalid !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
        vectors++; if (n >= TMO) begin miscompares++; $display("FAIL mid_beat2 rvalid got %b want 1", axi.rvalid); end
        rst = 1'b1;
        @(posedge clk); #1;
        vectors++; if ({axi.rvalid, axi.arready, axi.rlast} !== 3'b000) begin miscompares++; $display("FAIL mid_rst got rvalid/arready/rlast=%b want 000", {axi.rvalid, axi.arready, axi.rlast}); end
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++; if ({axi.arready, axi.awready, axi.rvalid} !== 3'b110) begin miscompares++; $display("FAIL mid_release got arready/awready/rvalid=%b want 110", {axi.arready, axi.awready, axi.rvalid}); end
        ar_put(6'h0D, 64'h20, 8'd0, e);
        r_get(d, resp, last, id, e);
        vectors++; if ({d, resp, last, id} !== {pat(32'hC0DE0001), OKAY, 1'b1, 6'h0D}) begin miscompares++; $display("FAIL mid_retained got id=%h resp=%b last=%b data=%h want 0d/00/1/c0de0001..", id, resp, last, d); end
    endtask

    initial begin
        axi.awvalid = 1'b0; axi.awid = '0; axi.awaddr = '0; axi.awlen = '0;
        axi.wvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0;
        axi.bready = 1'b0;
        axi.arvalid = 1'b0; axi.arid = '0; axi.araddr = '0; axi.arlen = '0;
        axi.rready = 1'b0;
        word0_exp = '0;
        test_reset();
        test_single_write();
        test_burst_strobe();
        test_out_of_range();
        test_early_wlast();
        test_back_to_back();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded 200000 ns, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end
endmodule
